// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan index sequencer.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int SCAN_BIT      = 3;
    localparam int SCAN_PRESCALE = 4;
    localparam int SCAN_PCNT_W   = 16;

    // Last index of a sweep: all-ones counting up, zero counting down.
    function automatic logic [31:0] term_idx(input int bits, input logic down);
        return down ? 32'd0 : ((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescale counter: tick is high for one cycle every PRESCALE cycles while not cleared.
// Latency: first tick PRESCALE cycles after clr drops; tick is decoded from the count register.
// Backpressure: none; clr holds the count at zero.
module scan_tick_gen
    import scan_pkg::*;
#(
    parameter int PRESCALE = SCAN_PRESCALE,
    parameter int PCNT_W   = SCAN_PCNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [PCNT_W-1:0] LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt;

    assign tick = !clr && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pcnt <= '0;
        end else if (pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_index_gen.sv
// Scan sequencer: steps idx through all 2^BIT codes every PRESCALE cycles, continuous or one-shot.
// Latency: en/busy rise 1 cycle after start is sampled; all outputs registered. SCAN_DIR_EN adds dir.
// Backpressure: none; stop aborts a running scan on the next cycle.
module scan_index_gen
    import scan_pkg::*;
#(
    parameter int BIT      = SCAN_BIT,
    parameter int PRESCALE = SCAN_PRESCALE,
    parameter int PCNT_W   = SCAN_PCNT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           one_shot,
`ifdef SCAN_DIR_EN
    input  logic           dir,
`endif
    output logic [BIT-1:0] idx,
    output logic           en,
    output logic           step,
    output logic           busy,
    output logic           done
);

    state_t state;
    logic   mode_q;
    logic   tick;

`ifdef SCAN_DIR_EN
    logic dir_q;
    logic dir_start;
    assign dir_start = dir;
`else
    localparam logic dir_q     = 1'b0;
    localparam logic dir_start = 1'b0;
`endif

    logic [BIT-1:0] first_idx;
    logic [BIT-1:0] last_idx;
    logic [BIT-1:0] next_idx;

    // A sweep starts at the terminal index of the opposite direction.
    assign first_idx = BIT'(term_idx(BIT, !dir_start));
    assign last_idx  = BIT'(term_idx(BIT, dir_q));
    assign next_idx  = dir_q ? (idx - BIT'(1)) : (idx + BIT'(1));

    scan_tick_gen #(
        .PRESCALE (PRESCALE),
        .PCNT_W   (PCNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != RUN),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            en     <= 1'b0;
            step   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
`ifdef SCAN_DIR_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idx  <= '0;
                    en   <= 1'b0;
                    busy <= 1'b0;
                    if (start && !stop) begin
                        state  <= RUN;
                        idx    <= first_idx;
                        en     <= 1'b1;
                        busy   <= 1'b1;
                        mode_q <= one_shot;
`ifdef SCAN_DIR_EN
                        dir_q  <= dir;
`endif
                    end
                end
                RUN: begin
                    // stop outranks a coincident step or end of sweep
                    if (stop) begin
                        state <= IDLE;
                        idx   <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (mode_q && (idx == last_idx)) begin
                            state <= FINISH;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx  <= next_idx;
                            step <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    idx   <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed bench for scan_index_gen: PRESCALE=4 instance for sweeps/abort/reset, PRESCALE=1 for wrap.
module tb_scan_index_gen;

    logic clk = 1'b0;
    logic rst, start, stop, os;
`ifdef SCAN_DIR_EN
    logic dir;
`endif

    logic [2:0] idx0, idx1;
    logic en0, step0, busy0, done0;
    logic en1, step1, busy1, done1;
    logic [6:0] o0, o1;

    int n_chk  = 0;
    int n_fail = 0;

    assign o0 = {idx0, en0, step0, busy0, done0};
    assign o1 = {idx1, en1, step1, busy1, done1};

    always #5 clk = ~clk;

    scan_index_gen #(.BIT(3), .PRESCALE(4), .PCNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(os),
`ifdef SCAN_DIR_EN
        .dir(dir),
`endif
        .idx(idx0), .en(en0), .step(step0), .busy(busy0), .done(done0)
    );

    scan_index_gen #(.BIT(3), .PRESCALE(1), .PCNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(os),
`ifdef SCAN_DIR_EN
        .dir(dir),
`endif
        .idx(idx1), .en(en1), .step(step1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       os;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [6:0] pk(input logic [2:0] i, input logic e, input logic s,
                                      input logic b, input logic d);
        return {i, e, s, b, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got idx=%0d en=%b step=%b busy=%b done=%b, want idx=%0d en=%b step=%b busy=%b done=%b",
                     nm, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One-shot sweep on the PRESCALE=4 instance, direction given by down.
    task automatic sweep(input logic down, input string nm);
        int steps;
        logic [2:0] e;
        steps = 0;
        start = 1'b1;
        os    = 1'b1;
`ifdef SCAN_DIR_EN
        dir   = down;
`endif
        for (int k = 1; k <= 32; k++) begin
            tick();
            start = 1'b0;
            os    = 1'b0;
            e = down ? 3'(7 - (k - 1) / 4) : 3'((k - 1) / 4);
            chk($sformatf("%s[%0d]", nm, k), o0, pk(e, 1'b1, (k > 1) && ((k - 1) % 4 == 0), 1'b1, 1'b0));
            if (step0) steps++;
        end
        tick();
        chk({nm, " done"}, o0, pk(down ? 3'd0 : 3'd7, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        chk({nm, " after"}, o0, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        n_chk++;
        if (steps != 7) begin
            n_fail++;
            $display("FAIL %s step count: got %0d, want 7", nm, steps);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, pk(3'd0, 1, 0, 1, 0)};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, pk(3'd1, 1, 1, 1, 0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, pk(3'd2, 1, 1, 1, 0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, pk(3'd3, 1, 1, 1, 0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, pk(3'd4, 1, 1, 1, 0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, pk(3'd5, 1, 1, 1, 0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, pk(3'd6, 1, 1, 1, 0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, pk(3'd7, 1, 1, 1, 0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, pk(3'd0, 1, 1, 1, 0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, pk(3'd1, 1, 1, 1, 0)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, pk(3'd0, 0, 0, 0, 0)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, pk(3'd0, 0, 0, 0, 0)};

        rst = 1'b1; start = 1'b0; stop = 1'b0; os = 1'b0;
`ifdef SCAN_DIR_EN
        dir = 1'b0;
`endif
        tick();
        tick();
        chk("reset", o0, pk(3'd0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("idle[%0d]", c), o0, pk(3'd0, 0, 0, 0, 0));
        end

        sweep(1'b0, "oneshot_up");

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start;
            stop  = tbl[i].stop;
            os    = tbl[i].os;
            tick();
            chk($sformatf("wrap[%0d]", i), o1, tbl[i].exp);
        end
        stop = 1'b0;

        // Abort at idx=5 with start held high throughout the run.
        start = 1'b1;
        os    = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            chk($sformatf("abort_run[%0d]", k), o0,
                pk(3'((k - 1) / 4), 1'b1, (k > 1) && ((k - 1) % 4 == 0), 1'b1, 1'b0));
        end
        stop = 1'b1;
        tick();
        chk("abort_stop", o0, pk(3'd0, 0, 0, 0, 0));
        tick();
        chk("start_and_stop_idle", o0, pk(3'd0, 0, 0, 0, 0));
        start = 1'b0;
        stop  = 1'b0;
        tick();
        chk("abort_idle", o0, pk(3'd0, 0, 0, 0, 0));

        // Reset mid-scan at idx=3.
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            start = 1'b0;
        end
        chk("pre_reset_idx3", o0, pk(3'd3, 1, 0, 1, 0));
        rst = 1'b1;
        tick();
        chk("mid_reset", o0, pk(3'd0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        chk("post_reset", o0, pk(3'd0, 0, 0, 0, 0));

`ifdef SCAN_DIR_EN
        sweep(1'b1, "oneshot_down");
        sweep(1'b0, "oneshot_dir0");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
